// File: rtl/util.sv
// Shared pipeline-register types, state encodings and access-size codes
// for the RV32 core; every pipeline stage imports this package.
package util_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc_plus_four;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] dmem_data;
      logic            dmem_rd_en;
      logic            dmem_wr_en;
      logic [1:0]      dmem_size;
      logic            dmem_sign;
      logic            reg_wr_en;
      logic [1:0]      reg_wr_sel;
      logic [4:0]      reg_wr_addr;
   } ex_ma_reg_t;

   typedef struct packed {
      logic            valid;
      logic            reg_wr_en;
      logic [1:0]      reg_wr_sel;
      logic [4:0]      reg_wr_addr;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] pc_plus_four;
      logic [XLEN-1:0] load_data;
   } ma_wb_reg_t;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      WAIT_GNT    = 2'd1,
      WAIT_RVALID = 2'd2,
      HOLD        = 2'd3
   } ma_state_t;

endpackage

// File: rtl/stage_ma_load_align.sv
// Load lane extraction: shift the read word down to the access offset, then select and extend.
// Latency: purely combinational.
// Backpressure: none; it is a datapath function only.
module dmem_load_align
   import util_pkg::*;
(
   input  logic [XLEN-1:0] rdata,
   input  logic [1:0]      offset,
   input  logic [1:0]      size,
   input  logic            sign,
   output logic [XLEN-1:0] load_data
);

   logic [XLEN-1:0] shifted;

   // A set sign bit selects the unsigned variant (LBU/LHU).
   always_comb begin
      shifted   = rdata >> {offset, 3'b000};
      load_data = shifted;
      case (size)
         SIZE_BYTE: load_data = sign ? {24'h000000, shifted[7:0]}
                                     : {{24{shifted[7]}}, shifted[7:0]};
         SIZE_HALF: load_data = sign ? {16'h0000, shifted[15:0]}
                                     : {{16{shifted[15]}}, shifted[15:0]};
         default:   load_data = shifted;
      endcase
   end

endmodule

// File: rtl/stage_ma.sv
// Memory-access stage: drives the req/gnt/rvalid data port and builds the MA-WB register.
// Latency: non-memory ops 0 added cycles; stores wait for grant; loads wait for grant plus rvalid.
// Backpressure: ma_stall_o freezes upstream while an access is open; stall_i holds MA-WB and parks completed ops in HOLD.
module stage_ma
   import util_pkg::*;
(
   input  logic        clk,
   input  logic        rst_i,
   input  ex_ma_reg_t  ex_ma_i,
   input  logic        stall_i,
   output logic        ma_stall_o,
   output logic        misalign_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [3:0]  dmem_be_o,
   output logic [31:0] dmem_wdata_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i,
   output ma_wb_reg_t  ma_wb_reg_o
);

   ma_state_t       state;
   logic [XLEN-1:0] load_buf;
   logic [XLEN-1:0] load_ext;
   logic            misalign_seen;
   logic [1:0]      offset;
   logic            mem_op;
   logic            misaligned;
   logic            aligned_op;
   logic            granted;
   logic            store_done;
   logic            load_done;

   assign offset = ex_ma_i.alu_result[1:0];
   assign mem_op = ex_ma_i.valid & (ex_ma_i.dmem_rd_en | ex_ma_i.dmem_wr_en);

   always_comb begin
      misaligned = 1'b0;
      case (ex_ma_i.dmem_size)
         SIZE_BYTE: misaligned = 1'b0;
         SIZE_HALF: misaligned = offset[0];
         default:   misaligned = (offset != 2'b00);
      endcase
   end

   assign aligned_op = mem_op & ~misaligned;

   // The request is a pure function of ex_ma_i and state, so it stays stable while ungranted.
   assign dmem_req_o   = ~rst_i & aligned_op & ((state == IDLE) | (state == WAIT_GNT));
   assign dmem_we_o    = ex_ma_i.dmem_wr_en;
   assign dmem_addr_o  = {ex_ma_i.alu_result[31:2], 2'b00};
   assign granted      = dmem_req_o & dmem_gnt_i;
   assign store_done   = granted & ex_ma_i.dmem_wr_en;
   assign load_done    = ~rst_i & (state == WAIT_RVALID) & dmem_rvalid_i;

   // One pulse per instruction even when stall_i keeps it sitting in MA.
   assign misalign_o = ~rst_i & mem_op & misaligned & ~misalign_seen & (state == IDLE);

   always_comb begin
      ma_stall_o = 1'b0;
      if (!rst_i) begin
         case (state)
            IDLE, WAIT_GNT: ma_stall_o = aligned_op & ~store_done;
            WAIT_RVALID:    ma_stall_o = ~dmem_rvalid_i;
            default:        ma_stall_o = 1'b0;
         endcase
      end
   end

   always_comb begin
      dmem_be_o    = 4'b1111;
      dmem_wdata_o = ex_ma_i.dmem_data;
      case (ex_ma_i.dmem_size)
         SIZE_BYTE: begin
            dmem_be_o    = 4'b0001 << offset;
            dmem_wdata_o = {4{ex_ma_i.dmem_data[7:0]}};
         end
         SIZE_HALF: begin
            dmem_be_o    = 4'b0011 << offset;
            dmem_wdata_o = {2{ex_ma_i.dmem_data[15:0]}};
         end
         default: begin
            dmem_be_o    = 4'b1111;
            dmem_wdata_o = ex_ma_i.dmem_data;
         end
      endcase
   end

   dmem_load_align u_load_align (
      .rdata     (dmem_rdata_i),
      .offset    (offset),
      .size      (ex_ma_i.dmem_size),
      .sign      (ex_ma_i.dmem_sign),
      .load_data (load_ext)
   );

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state         <= IDLE;
         misalign_seen <= 1'b0;
      end else begin
         misalign_seen <= stall_i & (misalign_seen | misalign_o);
         case (state)
            IDLE, WAIT_GNT: begin
               if (store_done)
                  state <= stall_i ? HOLD : IDLE;
               else if (granted)
                  state <= WAIT_RVALID;
               else if (dmem_req_o)
                  state <= WAIT_GNT;
               else
                  state <= IDLE;
            end
            WAIT_RVALID: begin
               if (dmem_rvalid_i)
                  state <= stall_i ? HOLD : IDLE;
            end
            HOLD: begin
               // The op already completed; leaving only on stall release keeps a store from reissuing.
               if (!stall_i)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (load_done)
         load_buf <= load_ext;
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         ma_wb_reg_o.valid     <= 1'b0;
         ma_wb_reg_o.reg_wr_en <= 1'b0;
      end else if (!stall_i) begin
         if (ma_stall_o) begin
            ma_wb_reg_o.valid     <= 1'b0;
            ma_wb_reg_o.reg_wr_en <= 1'b0;
         end else begin
            ma_wb_reg_o.valid        <= ex_ma_i.valid;
            ma_wb_reg_o.reg_wr_en    <= ex_ma_i.valid & ex_ma_i.reg_wr_en & ~(mem_op & misaligned);
            ma_wb_reg_o.reg_wr_sel   <= ex_ma_i.reg_wr_sel;
            ma_wb_reg_o.reg_wr_addr  <= ex_ma_i.reg_wr_addr;
            ma_wb_reg_o.alu_result   <= ex_ma_i.alu_result;
            ma_wb_reg_o.pc_plus_four <= ex_ma_i.pc_plus_four;
            ma_wb_reg_o.load_data    <= (state == HOLD) ? load_buf : load_ext;
         end
      end
   end

endmodule

// File: doc/stage_ma.md
# stage_ma

Memory-access stage of the 5-stage RISC-V pipeline. It consumes the EX-MA pipeline register and drives a request/grant/response data-memory port. It aligns store data and byte enables, and extracts and extends load data. It stalls the pipeline while an access is outstanding and produces the MA-WB pipeline register consumed by writeback.

## Interface
Parameters:
- none (XLEN fixed at 32)

Ports:
- clk  in  1  clock; one clock domain
- rst_i  in  1  reset; synchronous, active-high
- ex_ma_i  in  ex_ma_reg_t  EX-MA register contents: valid, pc_plus_four, alu_result, dmem_data, dmem_rd_en, dmem_wr_en, dmem_size, dmem_sign, reg_wr_en, reg_wr_sel, reg_wr_addr
- stall_i  in  1  hazard-unit stall; holds MA-WB register
- ma_stall_o  out  1  MA needs more cycles; hazard unit stalls IF..EX and inserts a WB bubble
- misalign_o  out  1  one-cycle pulse for a misaligned access; the access is not issued
- dmem_req_o  out  1  request valid; held until dmem_gnt_i
- dmem_we_o  out  1  1 = store
- dmem_addr_o  out  32  {alu_result[31:2], 2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  load data valid; single-cycle pulse, at earliest the cycle after grant
- dmem_rdata_i  in  32  load data
- ma_wb_reg_o  out  ma_wb_reg_t  MA-WB register: valid, reg_wr_en, reg_wr_sel, reg_wr_addr, alu_result, pc_plus_four, load_data

## Operation
- A memory op is `ex_ma_i.valid & (dmem_rd_en | dmem_wr_en)`.
- Misalignment is checked by dmem_size:
  - half with addr[0] set is misaligned;
  - word with addr[1:0] != 0 is misaligned.
- On a misaligned access:
  - pulse misalign_o;
  - issue no request;
  - pass the instruction to WB with reg_wr_en cleared.
- Byte enables and store data by size:
  - byte: be = 0001 << addr[1:0]; wdata = {4{dmem_data[7:0]}};
  - half: be = 0011 << addr[1:0]; wdata = {2{dmem_data[15:0]}};
  - word: be = 1111; wdata = dmem_data.
- Load extraction:
  - shift rdata right by addr[1:0]*8;
  - take 8, 16 or 32 bits per dmem_size;
  - dmem_sign = 1 zero-extends; 0 sign-extends.
- FSM states: IDLE, WAIT_GNT, WAIT_RVALID, HOLD.
  - IDLE: for an aligned memory op, assert dmem_req_o combinationally.
    - No grant: go to WAIT_GNT.
    - Grant on a store: the store is complete this cycle.
    - Grant on a load: go to WAIT_RVALID.
  - WAIT_GNT: keep dmem_req_o asserted with stable address, data and be until grant; on grant take the same transition as from IDLE.
  - WAIT_RVALID: on rvalid, capture the extracted load data into load_buf; the load is complete.
  - Completion with stall_i=0: the MA-WB register captures and the FSM returns to IDLE.
  - Completion with stall_i=1: go to HOLD.
  - HOLD: no new request, even though ex_ma_i is unchanged, so a store is never reissued. Stay until stall_i=0, then capture MA-WB (load_data from load_buf) and return to IDLE.
- ma_stall_o = 1 when a memory op is in MA and not completing this cycle. It is 0 in HOLD.
- MA-WB register update rules:
  - stall_i=1: hold the register.
  - stall_i=0 and ma_stall_o=1: write a bubble (valid=0, reg_wr_en=0).
  - otherwise: capture the current instruction.
- Non-memory instructions pass through with zero added latency.
- dmem_rvalid_i is ignored outside WAIT_RVALID.

## Timing
- Reset (synchronous):
  - FSM returns to IDLE;
  - ma_wb.valid = 0 and ma_wb.reg_wr_en = 0; other MA-WB fields undefined;
  - dmem_req_o, ma_stall_o and misalign_o are 0 in the cycle after reset.
- Reset mid-access abandons the transaction. A late rvalid after reset is ignored.
- Store granted the same cycle it is requested: 0 stall cycles.
- Load granted at cycle n with rvalid at n+k: ma_stall_o is high for cycles n..n+k-1, and MA-WB captures at the edge ending cycle n+k.
- dmem_req_o and the address, data and be outputs are combinational from ex_ma_i and FSM state. They must be stable while the request is ungranted.
- misalign_o is combinational, one cycle per instruction; it is suppressed while stall_i holds the same instruction.

## Structure
- Add ma_wb_reg_t and the ma_state_t enum to the shared typedef package in util.sv, alongside ex_ma_reg_t. Add the dmem_size encodings (BYTE=00, HALF=01, WORD=10) there as well.
- Sub-module dmem_load_align: purely combinational shift, select and extend (rdata, offset, size, sign -> 32-bit load_data).
- Store-lane generation stays inline.

## Test plan
- SW 0xDEADBEEF to 0x100 with gnt in the request cycle -> be=1111, wdata=0xDEADBEEF, ma_stall_o never high, one request issued.
- LB from 0x103 with rdata=0x80xxxxxx and rvalid 2 cycles after grant:
  - ma_stall_o high for exactly 2 cycles;
  - load_data=0xFFFFFF80;
  - LBU from the same address gives 0x00000080.
- SH 0x1234 to 0x202 with gnt delayed 3 cycles -> req held 4 cycles with stable addr=0x200, be=1100, wdata=0x12341234.
- LW from 0x101 -> misalign_o pulses once, no dmem_req_o, WB entry has reg_wr_en=0.
- Store completes while stall_i is high for 3 cycles -> FSM in HOLD, no second grant consumed. The store reaches WB once, when stall_i drops.
- rst_i asserted in WAIT_RVALID, then rvalid arrives -> ignored; ma_wb.valid=0, FSM in IDLE.
